// File: rtl/nvdla_hls_shift_pkg.sv
// nvdla_hls_shift_pkg: rounding modes and saturation constants for the shift/round/saturate pipe
package nvdla_hls_shift_pkg;
  typedef enum logic [1:0] {
    RND_HALF_AWAY = 2'd0,
    RND_FLOOR     = 2'd1,
    RND_HALF_EVEN = 2'd2
  } rnd_mode_e;

  function automatic logic [63:0] sat_val(input logic neg, input int ow);
    return neg ? {64{1'b1}} << (ow - 1) : (64'd1 << (ow - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/nvdla_hls_shift_lane.sv
// nvdla_hls_shift_lane: per-lane shift/guard/sticky (stage 0 side) and round/saturate (stage 1 side)
module nvdla_hls_shift_lane
  import nvdla_hls_shift_pkg::*;
#(
  parameter int IN_WIDTH    = 49,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic [IN_WIDTH-1:0]    x,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [OUT_WIDTH-1:0]   v,
  output logic                   guard,
  output logic                   sticky,
  output logic                   hi,
  output logic                   sign,
  input  logic [OUT_WIDTH-1:0]   r_v,
  input  logic                   r_guard,
  input  logic                   r_sticky,
  input  logic                   r_hi,
  input  logic                   r_sign,
  input  logic [1:0]             mode,
  output logic [OUT_WIDTH-1:0]   y,
  output logic                   sat
);
  // wide enough that the largest left shift never loses a bit before the overflow check
  localparam int WL = IN_WIDTH + 2 ** (SHIFT_WIDTH - 1);
  logic left, big, inc;
  logic [SHIFT_WIDTH-1:0] mag;
  logic [IN_WIDTH-1:0] one, rsh, gmask, smask;
  logic [WL-1:0] lsh;
  logic [OUT_WIDTH:0] sum;
  always_comb begin
    one    = IN_WIDTH'(1);
    left   = shift[SHIFT_WIDTH-1];
    mag    = -shift;
    big    = !left && (32'(shift) >= IN_WIDTH);
    rsh    = $signed(x) >>> shift;
    lsh    = WL'($signed(x)) << mag;
    gmask  = (left || shift == '0) ? '0 : one << (shift - SHIFT_WIDTH'(1));
    smask  = (gmask == '0) ? '0 : gmask - one;
    v      = left ? lsh[OUT_WIDTH-1:0] : big ? '0 : rsh[OUT_WIDTH-1:0];
    guard  = !left && !big && |(x & gmask);
    sticky = !left && !big && |(x & smask);
    hi     = left ? !(&lsh[WL-1:OUT_WIDTH-1] || ~|lsh[WL-1:OUT_WIDTH-1])
                  : !big && !(&rsh[IN_WIDTH-1:OUT_WIDTH-1] || ~|rsh[IN_WIDTH-1:OUT_WIDTH-1]);
    sign   = x[IN_WIDTH-1];
    inc    = mode == RND_FLOOR     ? 1'b0 :
             mode == RND_HALF_EVEN ? r_guard & (r_sticky | r_v[0]) :
                                     r_guard & (!r_sign | r_sticky);
    sum    = {r_v[OUT_WIDTH-1], r_v} + (OUT_WIDTH + 1)'(inc);
    sat    = r_hi || (sum[OUT_WIDTH] != sum[OUT_WIDTH-1]);
    y      = sat ? OUT_WIDTH'(sat_val(r_sign, OUT_WIDTH)) : sum[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/nvdla_hls_shiftrightss_pipe.sv
// nvdla_hls_shiftrightss_pipe: two-stage multi-lane signed shift/round/saturate with valid/ready and saturation counter
module nvdla_hls_shiftrightss_pipe
  import nvdla_hls_shift_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int IN_WIDTH    = 49,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rstn,
  input  logic                           in_pvld,
  output logic                           in_prdy,
  input  logic [LANES*IN_WIDTH-1:0]      in_data,
  input  logic [SHIFT_WIDTH-1:0]         in_shift,
  input  logic [1:0]                     in_rnd_mode,
  output logic                           out_pvld,
  input  logic                           out_prdy,
  output logic [LANES*OUT_WIDTH-1:0]     out_data,
  output logic [LANES-1:0]               out_sat,
  input  logic                           sat_cnt_clr,
  output logic [CNT_WIDTH-1:0]           sat_cnt
);
  localparam int PW = $clog2(LANES + 1);
  logic s0_vld, s1_vld, s1_load;
  logic [1:0] s0_mode;
  logic [LANES-1:0][OUT_WIDTH-1:0] v, s0_v, y;
  logic [LANES-1:0] gd, sk, hi, sg, s0_gd, s0_sk, s0_hi, s0_sg, sat;
  logic [PW-1:0] pop;
  logic [CNT_WIDTH:0] cnt_sum;

  assign s1_load  = !s1_vld || out_prdy;
  assign in_prdy  = !s0_vld || s1_load;
  assign out_pvld = s1_vld;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    nvdla_hls_shift_lane #(
      .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .x(in_data[i*IN_WIDTH +: IN_WIDTH]), .shift(in_shift),
      .v(v[i]), .guard(gd[i]), .sticky(sk[i]), .hi(hi[i]), .sign(sg[i]),
      .r_v(s0_v[i]), .r_guard(s0_gd[i]), .r_sticky(s0_sk[i]), .r_hi(s0_hi[i]), .r_sign(s0_sg[i]),
      .mode(s0_mode), .y(y[i]), .sat(sat[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(out_sat[i]);
    cnt_sum = {1'b0, sat_cnt} + (CNT_WIDTH + 1)'(pop);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (in_pvld && in_prdy) begin
      s0_v    <= v;
      s0_gd   <= gd;
      s0_sk   <= sk;
      s0_hi   <= hi;
      s0_sg   <= sg;
      s0_mode <= in_rnd_mode;
    end
  end

  // the counter sticks at all-ones instead of wrapping; clear beats a same-cycle increment
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      s0_vld   <= 1'b0;
      s1_vld   <= 1'b0;
      out_data <= '0;
      out_sat  <= '0;
      sat_cnt  <= '0;
    end else begin
      if (in_prdy) s0_vld <= in_pvld;
      if (s1_load) s1_vld <= s0_vld;
      if (s1_load && s0_vld) begin
        out_data <= y;
        out_sat  <= sat;
      end
      sat_cnt <= sat_cnt_clr ? '0 :
                 (out_pvld && out_prdy) ? (cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0]) :
                 sat_cnt;
    end
  end
endmodule
